// File: rtl/pes_s2p_pkg.sv
// Shared types for the serial-to-parallel collector: FSM state encoding and counter sizing.
package pes_s2p_pkg;

    typedef enum logic [1:0] {
        S_COLLECT,
        S_PARITY,
        S_STALL
    } s2p_state_t;

    function automatic int s2p_cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/pes_serial_to_parallel.sv
// Serial bit stream to MSB-first WIDTH-bit words, valid/ready on both sides, two-word buffering.
// Optional trailing even-parity bit per word when PES_S2P_PARITY_EN is defined.
module pes_serial_to_parallel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             sin,
    input  logic             sin_valid,
    output logic             sin_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             parity_err
);
    import pes_s2p_pkg::*;

    localparam int                CNT_W    = s2p_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    s2p_state_t       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             ready_q;
    logic             bit_acc;
    logic             out_free;
    logic             done;
    logic [WIDTH-1:0] done_word;
`ifdef PES_S2P_PARITY_EN
    logic             perr_q, perr_d;
    logic             hold_perr_q, hold_perr_d;
    logic             done_perr;
`endif

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done        = 1'b0;
        done_word   = sr_q;
`ifdef PES_S2P_PARITY_EN
        perr_d      = perr_q;
        hold_perr_d = hold_perr_q;
        done_perr   = 1'b0;
`endif
        bit_acc  = sin_valid && ready_q;
        out_free = !out_valid_q || out_ready;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_COLLECT: begin
                if (bit_acc) begin
                    sr_d = {sr_q[WIDTH-2:0], sin};
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
`ifdef PES_S2P_PARITY_EN
                        state_d = S_PARITY;
`else
                        done      = 1'b1;
                        done_word = sr_d;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
`ifdef PES_S2P_PARITY_EN
                // Parity bit is checked but never shifted in; sr already holds the word.
                if (bit_acc) begin
                    done      = 1'b1;
                    done_word = sr_q;
                    done_perr = ^{sr_q, sin};
                end
`else
                state_d = S_COLLECT;
`endif
            end
            S_STALL: begin
                if (out_ready) begin
                    out_data_d  = sr_q;
                    out_valid_d = 1'b1;
                    state_d     = S_COLLECT;
`ifdef PES_S2P_PARITY_EN
                    perr_d = hold_perr_q;
`endif
                end
            end
            default: state_d = S_COLLECT;
        endcase

        if (done) begin
            if (out_free) begin
                out_data_d  = done_word;
                out_valid_d = 1'b1;
                state_d     = S_COLLECT;
`ifdef PES_S2P_PARITY_EN
                perr_d = done_perr;
`endif
            end else begin
                state_d = S_STALL;
`ifdef PES_S2P_PARITY_EN
                hold_perr_d = done_perr;
`endif
            end
        end
    end

    // sin_ready is registered from the next state so out_ready never reaches it combinationally.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= S_COLLECT;
            sr_q        <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ready_q     <= (state_d != S_STALL);
        end
    end

`ifdef PES_S2P_PARITY_EN
    always_ff @(posedge clk) begin
        if (!nrst) begin
            perr_q      <= 1'b0;
            hold_perr_q <= 1'b0;
        end else begin
            perr_q      <= perr_d;
            hold_perr_q <= hold_perr_d;
        end
    end
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign sin_ready = ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/pes_serial_to_parallel.md
# pes_serial_to_parallel

Collects a serial bit stream into WIDTH-bit parallel words with valid/ready flow control on both sides. Sits directly upstream of the team's bit-order reversal stage: words leave MSB-first (first received bit in `out_data[WIDTH-1]`), and the reversal stage converts them to LSB-first order where a link requires it. Holds one completed word in the output register and a second in the shift register, so the serial side stalls only when both are full.

## Interface
- `WIDTH`, 8, word width in bits; must be ≥2.
- `clk`  input  1  clock; all state updates on the rising edge.
- `nrst`  input  1  reset, synchronous, active-low.
- `sin`  input  1  serial data bit.
- `sin_valid`  input  1  `sin` carries a bit this cycle.
- `sin_ready`  output  1  block accepts a bit this cycle.
- `out_data`  output  WIDTH  assembled word, MSB = first received bit.
- `out_valid`  output  1  `out_data` holds a word.
- `out_ready`  input  1  consumer takes the word this cycle.
- `parity_err`  output  1  parity flag for the word in `out_data`; constant 0 without the parity feature.

## Operation
- A bit is accepted on an edge where `sin_valid && sin_ready`. A word is taken on an edge where `out_valid && out_ready`.
- Shift register `sr`: `sr <= {sr[WIDTH-2:0], sin}` on each accepted data bit.
- Counter `cnt`, $clog2(WIDTH) bits, counts accepted data bits from 0 to WIDTH-1 and wraps to 0 after the last bit.
- States:
  - COLLECT: `sin_ready`=1. On the accepted bit where `cnt`==WIDTH-1 the word is complete; it goes to DONE.
  - PARITY: exists only with the parity feature; `sin_ready`=1. Accepts one parity bit, then goes to DONE.
  - STALL: `sin_ready`=0. The completed word is held in `sr`.
- DONE is an event on the completing edge, not a state:
  - If the output register is free (`!out_valid || out_ready`), the word loads into `out_data`, `out_valid`<=1, and the state is COLLECT.
  - Otherwise the state is STALL.
- In STALL, on the edge where `out_ready` is high, `sr` loads into `out_data`, `out_valid` stays 1, and the state returns to COLLECT.
- When the output register is taken and no new word loads, `out_valid`<=0.
- A take and a load on the same edge are both legal; the new word replaces the old one with no bubble.
- `out_data` and `parity_err` are stable while `out_valid && !out_ready`.

## Timing
- Reset (`nrst`=0 at an edge) clears all state:
  - `out_valid`=0, `out_data`=0, `parity_err`=0, `sr`=0, `cnt`=0, state COLLECT.
  - `sin_ready` is 1 from the first cycle after reset.
- Reset in the middle of a word discards the partial word and any held word. No output is produced for them.
- Latency: `out_valid` is high in the cycle after the edge that accepts the last bit (the last data bit, or the parity bit).
- Throughput: 1 bit per cycle with no bubbles between words while `out_ready` is held high.
- Back-pressure: at most one full word in `out_data` plus one in `sr`. `sin_ready` drops only in STALL.
- `sin_ready` is a registered function of the state only. It has no combinational path from `out_ready`.

## Configuration
- Macro `PES_S2P_PARITY_EN`.
- Defined:
  - Each word is followed by one even-parity bit on `sin` (XOR of the WIDTH data bits and the parity bit must be 0).
  - `parity_err` is registered together with `out_data` and is 1 when the check fails.
  - A word is WIDTH+1 serial bits long.
- Undefined:
  - No PARITY state; a word is WIDTH serial bits long.
  - `parity_err` is tied to 0.

## Structure
- Package `pes_s2p_pkg` holds:
  - the state typedef `s2p_state_t` {S_COLLECT, S_PARITY, S_STALL};
  - the width function for `cnt`.
- Single module. No sub-module is needed: the shift register, counter and output register are each a few lines of code.

## Test plan
1. Reset, then bits 1,0,1,1,0,0,1,0 on consecutive cycles with `out_ready`=1 (WIDTH=8) -> `out_data`=8'hB2 and `out_valid`=1 for exactly one cycle, starting the cycle after the 8th bit.
2. Two words back-to-back, 16 consecutive bits encoding 8'hB2 then 8'h5A, with `out_ready`=1 -> `sin_ready` stays 1 throughout, and the two words appear 8 cycles apart.
3. `out_ready`=0 while 16 bits are sent -> `sin_ready` drops after the 16th bit and `out_data` holds 8'hB2. Raise `out_ready` for one cycle -> `out_data`=8'h5A on the next cycle and `sin_ready` returns to 1.
4. Assert reset after 5 bits, then send a full word of 8'hFF -> output is 8'hFF only; there is no trace of the partial word.
5. With `PES_S2P_PARITY_EN`: send 8'hB2 with parity bit 0 -> `parity_err`=0. Send 8'hB2 with parity bit 1 -> `parity_err`=1 alongside `out_data`=8'hB2.
6. Random `sin_valid` and `out_ready` over 10k cycles -> every word is delivered exactly once, in order, and `out_data` never changes while `out_valid && !out_ready`.
